i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  I2C target (slave) answering one 7-bit address; counterpart to the on-chip i2c_master.
//  Filters SDA/SCL, detects START/Sr/STOP, ACKs its address, hands received bytes to the local
//  side (rx_stb) and fetches transmit bytes from it (tx_req/tx_vld). Open-drain style: *_out=1 releases.
// PARAMETERS
//  ADDR  7'h50  own 7-bit address
//  US    1      clk cycles per microsecond; HOLD=3*US/10, SU_DATA=3*US/10 (min 1 each)
//  FILT  2      filter depth: a line level is accepted after FILT equal consecutive samples
// PORTS
//  clk      in   1  clock
//  rst      in   1  asynchronous reset, active-low
//  sda      in   1  SDA bus level
//  sda_out  out  1  SDA drive (0=pull low, 1=release)
//  scl      in   1  SCL bus level
//  scl_out  out  1  SCL drive (0 only for clock stretching)
//  rx_dat   out  8  last received data byte
//  rx_stb   out  1  1-cycle pulse: rx_dat valid (write byte received)
//  tx_dat   in   8  byte to transmit
//  tx_req   out  1  1-cycle pulse: supply next tx_dat
//  tx_vld   in   1  tx_dat valid; sampled on/after tx_req, until the byte is consumed
//  sel      out  1  level: addressed, transaction in progress
//  rw       out  1  R/W bit of current transaction (1=read)
//  sto      out  1  1-cycle pulse: STOP seen while sel
//  udr      out  1  1-cycle pulse: tx underrun (0xFF sent)
// BEHAVIOUR
//  - Reset: sda_out=1, scl_out=1, rx_dat=0, rx_stb=0, tx_req=0, sel=0, rw=0, sto=0, udr=0; state IDLE.
//    Reset mid-transfer releases both lines in the same cycle; block ignores bus until next START.
//  - Inputs: 2-FF sync then FILT filter (sf/cf); edges derived from filtered levels only.
//  - START/Sr: sf falls while cf=1 -> ADDR, bit count 7, sda_out=1; valid from any state.
//    STOP: sf rises while cf=1 -> IDLE, release, sel=0, sto pulse if sel was 1.
//    SDA change while SCL high is never sampled as data (START/STOP priority).
//  - Data sampled on cf rise, MSB first; SDA driven HOLD cycles after cf fall.
//  - States: IDLE, ADDR, AACK, RX, RACK, TX, TACK (master ack), WAIT (ignore until START/STOP).
//  - ADDR: 8 bits; match {ADDR,rw} -> AACK: drive 0 from fall+HOLD of bit 8 to fall+HOLD of ack bit;
//    sel=1, rw latched. Mismatch -> WAIT, no ACK, no pulses.
//  - Write: AACK -> RX; after 8th bit rx_dat updated, rx_stb pulse, RACK (always ACK), RX again.
//  - Read: tx_req pulses on cf rise of AACK/TACK-with-ACK. Byte loaded at next cf fall+HOLD if
//    tx_vld=1 (feature below otherwise); 8 bits out then TACK: release SDA, sample master ACK on rise.
//    ACK(0) -> next byte; NACK(1) -> WAIT.
//  - rx_stb and tx_req never both asserted; tx_req never issued while rw=0.
//  - Bit counter 3 bits, wraps 0->7 only at byte boundary (entry into ACK state).
// CONFIGURATION
//  I2C_SLAVE_STRETCH_EN defined: tx_vld=0 at load point -> scl_out=0 until tx_vld=1, then drive MSB,
//    wait SU_DATA cycles, release SCL; udr never asserted.
//  Not defined: scl_out tied 1; tx_vld=0 at load point -> send 8'hFF, udr pulse.
// STRUCTURE
//  Shared include i2c_defs.vh: state encodings, HOLD/SU_DATA/US-derived timing constants,
//    width-from-period localparam trick used by all i2c blocks.
//  Sub-module i2c_line_filter (sync + FILT filter + rise/fall pulses), instanced for SDA and SCL.
// TESTING (bench models open-drain bus: level = AND of all drivers; master at 100 kHz, US=10)
//  1 START, 0xA0, 0x5A, STOP -> ACK both bytes; rx_stb once, rx_dat=0x5A; sto pulse; sel 1 then 0.
//  2 START, 0xA4 (addr 0x52) -> SDA never pulled low, sel=0, no rx_stb/tx_req; next START 0xA0 ACKed.
//  3 START, 0xA1, tx_dat=0xC3 vld at tx_req, master NACK, STOP -> bus bits 1100_0011; one tx_req; WAIT.
//  4 Read, tx_vld delayed 20us -> STRETCH_EN: scl low >=20us, byte 0xC3; else byte 0xFF + udr.
//  5 Write 0x11, Sr, 0xA1 read 2 bytes (ACK, NACK) -> rx_stb 0x11, two tx_req, rw 0->1.
//  6 Reset asserted while slave drives ACK -> sda_out=1 same cycle; 1-cycle SDA glitch with SCL high
//    (FILT=2) -> no START detected.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
//-----------------------------------------------------------------------------
//  Module      : i2c_slave_pkg
//  Description : Shared constants for the I2C target: FSM state encodings and
//                helpers that turn microsecond-scaled timing into cycle
//                counts and counter widths.
//  Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

package i2c_slave_pkg;

    // FSM state encodings
    localparam logic [2:0] c_st_idle = 3'd0;  // bus ignored until START
    localparam logic [2:0] c_st_addr = 3'd1;  // shifting in address + R/W
    localparam logic [2:0] c_st_aack = 3'd2;  // driving address ACK
    localparam logic [2:0] c_st_rx   = 3'd3;  // receiving write data
    localparam logic [2:0] c_st_rack = 3'd4;  // driving data ACK
    localparam logic [2:0] c_st_tx   = 3'd5;  // sending read data
    localparam logic [2:0] c_st_tack = 3'd6;  // sampling master ACK
    localparam logic [2:0] c_st_wait = 3'd7;  // not ours / NACKed: wait for START/STOP

    // A timing interval of zero cycles is meaningless on the bus; clamp to 1.
    function automatic int f_cycles_min1(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    // Counter width able to hold the value max_val.
    function automatic int f_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
//-----------------------------------------------------------------------------
//  Module      : i2c_line_filter
//  Description : Two-flop synchroniser followed by a FILT-deep majority-free
//                glitch filter; the filtered level only changes after FILT
//                consecutive equal samples. Registered rise/fall pulses are
//                coincident with the filtered level change.
//  Ports       : clk, rst (async, active-low)
//                i_line  raw bus level
//                o_level filtered level (idles high)
//                o_rise  1-cycle pulse, filtered level went 0->1
//                o_fall  1-cycle pulse, filtered level went 1->0
//  Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module i2c_line_filter #(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]      r_sync;
    logic [FILT-1:0] r_hist;
    logic [FILT-1:0] w_hist_nxt;
    logic            r_level;
    logic            r_rise;
    logic            r_fall;

    generate
        if (FILT == 1) begin : g_filt_single
            assign w_hist_nxt = r_sync[1];
        end else begin : g_filt_multi
            assign w_hist_nxt = {r_hist[FILT-2:0], r_sync[1]};
        end
    endgenerate

    // Released bus lines read high, so every stage resets to 1: no false
    // edge is produced when reset is removed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync  <= '1;
            r_hist  <= '1;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= w_hist_nxt;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if ((&r_hist) && !r_level) begin
                r_level <= 1'b1;
                r_rise  <= 1'b1;
            end else if (!(|r_hist) && r_level) begin
                r_level <= 1'b0;
                r_fall  <= 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
//-----------------------------------------------------------------------------
//  Module      : i2c_slave
//  Description : I2C target answering one 7-bit address. Filters SDA/SCL,
//                detects START/Sr/STOP, ACKs its address, delivers write
//                bytes (rx_stb) and fetches read bytes (tx_req/tx_vld).
//                Open-drain outputs: 1 releases the line.
//  Config      : I2C_SLAVE_STRETCH_EN - when defined, a missing read byte
//                stretches SCL until tx_vld; otherwise 0xFF is sent and udr
//                pulses.
//  Ports       : clk, rst (async, active-low)
//                sda/scl in, sda_out/scl_out drive, rx_dat/rx_stb write data,
//                tx_dat/tx_vld/tx_req read data, sel/rw/sto/udr status
//  Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h50,
    parameter int         US   = 1,
    parameter int         FILT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda,
    output logic       sda_out,
    input  logic       scl,
    output logic       scl_out,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    input  logic [7:0] tx_dat,
    output logic       tx_req,
    input  logic       tx_vld,
    output logic       sel,
    output logic       rw,
    output logic       sto,
    output logic       udr
);

    localparam int                  c_hold    = f_cycles_min1((3 * US) / 10);
    localparam int                  c_hold_w  = f_width(c_hold);
    localparam logic [c_hold_w-1:0] c_hold_ld = c_hold_w'(c_hold);

    logic w_sf, w_s_rise, w_s_fall;
    logic w_cf, w_c_rise, w_c_fall;

    i2c_line_filter #(.FILT(FILT)) u_sda_filt (
        .clk(clk), .rst(rst), .i_line(sda),
        .o_level(w_sf), .o_rise(w_s_rise), .o_fall(w_s_fall)
    );

    i2c_line_filter #(.FILT(FILT)) u_scl_filt (
        .clk(clk), .rst(rst), .i_line(scl),
        .o_level(w_cf), .o_rise(w_c_rise), .o_fall(w_c_fall)
    );

    logic [2:0]          r_state;
    logic [2:0]          r_cnt;
    logic [6:0]          r_rx_sh;    // first 7 bits of the byte being received
    logic [6:0]          r_tx_sh;    // remaining bits of the byte being sent
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_need_load;
    logic                r_sda_out;
    logic [7:0]          r_rx_dat;
    logic                r_rx_stb, r_tx_req, r_sel, r_rw, r_sto, r_udr;
    logic [7:0]          w_byte;
    logic                w_hold_hit;

`ifdef I2C_SLAVE_STRETCH_EN
    localparam int                c_su    = f_cycles_min1((3 * US) / 10);
    localparam int                c_su_w  = f_width(c_su);
    localparam logic [c_su_w-1:0] c_su_ld = c_su_w'(c_su);
    logic              r_scl_out;
    logic              r_stretch;
    logic [c_su_w-1:0] r_su_cnt;
`endif

    assign w_byte     = {r_rx_sh, w_sf};
    assign w_hold_hit = (r_hold_cnt == c_hold_w'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= 3'd7;
            r_rx_sh     <= '0;
            r_tx_sh     <= '1;
            r_hold_cnt  <= '0;
            r_need_load <= 1'b0;
            r_sda_out   <= 1'b1;
            r_rx_dat    <= '0;
            r_rx_stb    <= 1'b0;
            r_tx_req    <= 1'b0;
            r_sel       <= 1'b0;
            r_rw        <= 1'b0;
            r_sto       <= 1'b0;
            r_udr       <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
            r_scl_out   <= 1'b1;
            r_stretch   <= 1'b0;
            r_su_cnt    <= '0;
`endif
        end else begin
            r_rx_stb <= 1'b0;
            r_tx_req <= 1'b0;
            r_sto    <= 1'b0;
            r_udr    <= 1'b0;

            // SDA is changed a hold time after SCL falls
            if (w_c_fall)
                r_hold_cnt <= c_hold_ld;
            else if (r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - 1'b1;

            if (w_s_fall && w_cf) begin
                // START / repeated START, accepted from any state
                r_state     <= c_st_addr;
                r_cnt       <= 3'd7;
                r_sda_out   <= 1'b1;
                r_hold_cnt  <= '0;
                r_need_load <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
                r_scl_out   <= 1'b1;
                r_stretch   <= 1'b0;
`endif
            end else if (w_s_rise && w_cf) begin
                // STOP
                r_state     <= c_st_idle;
                r_sda_out   <= 1'b1;
                r_sel       <= 1'b0;
                r_sto       <= r_sel;
                r_hold_cnt  <= '0;
                r_need_load <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
                r_scl_out   <= 1'b1;
                r_stretch   <= 1'b0;
`endif
            end else begin
                // ---- drive point ----
                if (w_hold_hit) begin
                    case (r_state)
                        c_st_aack, c_st_rack: r_sda_out <= 1'b0;
                        c_st_tx: begin
                            if (r_need_load) begin
                                if (tx_vld) begin
                                    r_sda_out   <= tx_dat[7];
                                    r_tx_sh     <= tx_dat[6:0];
                                    r_need_load <= 1'b0;
                                end else begin
`ifdef I2C_SLAVE_STRETCH_EN
                                    // hold SCL low until the local side delivers
                                    r_scl_out <= 1'b0;
                                    r_stretch <= 1'b1;
`else
                                    r_sda_out   <= 1'b1;
                                    r_tx_sh     <= '1;
                                    r_need_load <= 1'b0;
                                    r_udr       <= 1'b1;
`endif
                                end
                            end else begin
                                r_sda_out <= r_tx_sh[6];
                                r_tx_sh   <= {r_tx_sh[5:0], 1'b1};
                            end
                        end
                        c_st_idle: ;
                        default: r_sda_out <= 1'b1;
                    endcase
                end

`ifdef I2C_SLAVE_STRETCH_EN
                // Late byte: drive MSB, then give it a setup time before
                // letting SCL go.
                if (r_stretch) begin
                    if (r_need_load) begin
                        if (tx_vld) begin
                            r_sda_out   <= tx_dat[7];
                            r_tx_sh     <= tx_dat[6:0];
                            r_need_load <= 1'b0;
                            r_su_cnt    <= c_su_ld;
                        end
                    end else if (r_su_cnt > c_su_w'(1)) begin
                        r_su_cnt <= r_su_cnt - 1'b1;
                    end else begin
                        r_scl_out <= 1'b1;
                        r_stretch <= 1'b0;
                    end
                end
`endif

                // ---- sample point ----
                if (w_c_rise) begin
                    case (r_state)
                        c_st_addr: begin
                            r_rx_sh <= w_byte[6:0];
                            if (r_cnt == 3'd0) begin
                                r_cnt <= 3'd7;
                                if (w_byte[7:1] == ADDR) begin
                                    r_state <= c_st_aack;
                                    r_sel   <= 1'b1;
                                    r_rw    <= w_byte[0];
                                end else begin
                                    r_state <= c_st_wait;
                                    r_sel   <= 1'b0;
                                end
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                        c_st_aack: begin
                            if (r_rw) begin
                                r_state     <= c_st_tx;
                                r_tx_req    <= 1'b1;
                                r_need_load <= 1'b1;
                            end else begin
                                r_state <= c_st_rx;
                            end
                        end
                        c_st_rx: begin
                            r_rx_sh <= w_byte[6:0];
                            if (r_cnt == 3'd0) begin
                                r_rx_dat <= w_byte;
                                r_rx_stb <= 1'b1;
                                r_state  <= c_st_rack;
                                r_cnt    <= 3'd7;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                        c_st_rack: r_state <= c_st_rx;
                        c_st_tx: begin
                            if (r_cnt == 3'd0) begin
                                r_state <= c_st_tack;
                                r_cnt   <= 3'd7;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                        c_st_tack: begin
                            if (!w_sf) begin
                                r_state     <= c_st_tx;
                                r_tx_req    <= 1'b1;
                                r_need_load <= 1'b1;
                            end else begin
                                r_state <= c_st_wait;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign sda_out = r_sda_out;
`ifdef I2C_SLAVE_STRETCH_EN
    assign scl_out = r_scl_out;
`else
    assign scl_out = 1'b1;
`endif
    assign rx_dat  = r_rx_dat;
    assign rx_stb  = r_rx_stb;
    assign tx_req  = r_tx_req;
    assign sel     = r_sel;
    assign rw      = r_rw;
    assign sto     = r_sto;
    assign udr     = r_udr;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
//-----------------------------------------------------------------------------
//  Module      : tb_i2c_slave
//  Description : Directed self-checking bench for i2c_slave. Open-drain bus
//                (wired AND of master and target drivers), master at
//                100 kHz with US=10 (100 clk cycles per SCL period).
//  Revision    : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_slave;

    localparam int US = 10;
    localparam int FILT = 2;
    localparam int Q = 25;       // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       m_sda = 1'b1;
    logic       m_scl = 1'b1;
    logic [7:0] tx_dat = 8'hC3;
    logic       tx_vld = 1'b1;
    wire        sda_bus, scl_bus;
    wire        sda_out, scl_out, rx_stb, tx_req, sel, rw, sto, udr;
    wire  [7:0] rx_dat;

    assign sda_bus = m_sda & sda_out;
    assign scl_bus = m_scl & scl_out;

    always #50 clk = ~clk;

    i2c_slave #(.ADDR(7'h50), .US(US), .FILT(FILT)) dut (
        .clk(clk), .rst(rst),
        .sda(sda_bus), .sda_out(sda_out),
        .scl(scl_bus), .scl_out(scl_out),
        .rx_dat(rx_dat), .rx_stb(rx_stb),
        .tx_dat(tx_dat), .tx_req(tx_req), .tx_vld(tx_vld),
        .sel(sel), .rw(rw), .sto(sto), .udr(udr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // event monitor (samples on the inactive edge)
    int         n_rx = 0, n_txreq = 0, n_sto = 0, n_udr = 0, n_both = 0, n_sda_low = 0;
    int         scl_run = 0, scl_max = 0;
    logic [7:0] last_rx = 8'h00;

    always @(negedge clk) begin
        if (rx_stb) begin n_rx++; last_rx = rx_dat; end
        if (tx_req) n_txreq++;
        if (sto) n_sto++;
        if (udr) n_udr++;
        if (rx_stb && tx_req) n_both++;
        if (sda_out === 1'b0) n_sda_low++;
        if (scl_out === 1'b0) begin
            scl_run++;
            if (scl_run > scl_max) scl_max = scl_run;
        end else begin
            scl_run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Honour clock stretching, bounded
    task automatic wait_scl_high();
        int k = 0;
        while (scl_bus !== 1'b1 && k < 3000) begin tick(1); k++; end
        if (k >= 3000) begin
            n_tests++; n_fail++;
            $display("FAIL scl_release_timeout: scl=%b expected 1", scl_bus);
        end
    endtask

    task automatic bit_io(input logic b, output logic rd);
        m_sda = b;  tick(Q);
        m_scl = 1'b1; wait_scl_high(); tick(Q);
        rd = sda_bus; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic start_c();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1; tick(Q);
            m_scl = 1'b1; wait_scl_high(); tick(Q);
        end
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; wait_scl_high(); tick(Q);
        m_sda = 1'b1; tick(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic rd;
        for (int i = 7; i >= 0; i--) bit_io(d[i], rd);
        bit_io(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic rd;
        for (int i = 7; i >= 0; i--) begin bit_io(1'b1, rd); d[i] = rd; end
        bit_io(mack, rd);
    endtask

    task automatic test_reset();
        rst = 1'b0; tick(3);
        n_tests++;
        if ({sda_out, scl_out, rx_dat, rx_stb, tx_req, sel, rw, sto, udr} !== 16'hC000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected c000",
                     {sda_out, scl_out, rx_dat, rx_stb, tx_req, sel, rw, sto, udr});
        end
        rst = 1'b1; tick(20);
    endtask

    task automatic test_write();
        logic a0, a1; int rx0, sto0;
        rx0 = n_rx; sto0 = n_sto;
        start_c(); write_byte(8'hA0, a0);
        n_tests++;
        if (sel !== 1'b1 || rw !== 1'b0) begin n_fail++; $display("FAIL wr_sel_rw: got sel=%b rw=%b expected sel=1 rw=0", sel, rw); end
        write_byte(8'h5A, a1);
        n_tests++;
        if ({a0, a1} !== 2'b00) begin n_fail++; $display("FAIL wr_acks: got %b expected 00", {a0, a1}); end
        stop_c();
        n_tests++;
        if (n_rx - rx0 != 1 || last_rx !== 8'h5A) begin n_fail++; $display("FAIL wr_rx: got count=%0d dat=%h expected count=1 dat=5a", n_rx - rx0, last_rx); end
        n_tests++;
        if (n_sto - sto0 != 1 || sel !== 1'b0) begin n_fail++; $display("FAIL wr_stop: got sto=%0d sel=%b expected sto=1 sel=0", n_sto - sto0, sel); end
    endtask

    task automatic test_addr_mismatch();
        logic a; int low0, rx0, tr0;
        low0 = n_sda_low; rx0 = n_rx; tr0 = n_txreq;
        start_c(); write_byte(8'hA4, a);
        n_tests++;
        if (a !== 1'b1 || sel !== 1'b0 || n_sda_low != low0) begin
            n_fail++; $display("FAIL mis_noack: got ack=%b sel=%b lowcyc=%0d expected ack=1 sel=0 lowcyc=0", a, sel, n_sda_low - low0);
        end
        n_tests++;
        if (n_rx != rx0 || n_txreq != tr0) begin n_fail++; $display("FAIL mis_pulses: got rx=%0d txreq=%0d expected 0 0", n_rx - rx0, n_txreq - tr0); end
        start_c(); write_byte(8'hA0, a);
        n_tests++;
        if (a !== 1'b0 || sel !== 1'b1) begin n_fail++; $display("FAIL mis_recover: got ack=%b sel=%b expected ack=0 sel=1", a, sel); end
        stop_c();
    endtask

    task automatic test_read_nack();
        logic a; logic [7:0] d; int tr0, sto0, u0;
        tr0 = n_txreq; sto0 = n_sto; u0 = n_udr;
        tx_dat = 8'hC3; tx_vld = 1'b1;
        start_c(); write_byte(8'hA1, a);
        n_tests++;
        if (a !== 1'b0 || rw !== 1'b1) begin n_fail++; $display("FAIL rd_addr: got ack=%b rw=%b expected ack=0 rw=1", a, rw); end
        read_byte(1'b1, d);
        n_tests++;
        if (d !== 8'hC3) begin n_fail++; $display("FAIL rd_byte: got %h expected c3", d); end
        stop_c();
        n_tests++;
        if (n_txreq - tr0 != 1 || n_udr != u0 || n_sto - sto0 != 1) begin
            n_fail++; $display("FAIL rd_pulses: got txreq=%0d udr=%0d sto=%0d expected 1 0 1", n_txreq - tr0, n_udr - u0, n_sto - sto0);
        end
    endtask

    task automatic test_underrun_stretch();
        logic a; logic [7:0] d; int u0;
        u0 = n_udr;
        tx_vld = 1'b0;
        fork
            begin : g_supplier
                int k = 0;
`ifdef I2C_SLAVE_STRETCH_EN
                while (scl_out !== 1'b0 && k < 5000) begin tick(1); k++; end
`else
                while (tx_req !== 1'b1 && k < 5000) begin tick(1); k++; end
`endif
                if (k >= 5000) begin
                    n_tests++; n_fail++;
                    $display("FAIL late_vld_trigger_timeout: waited %0d cycles", k);
                end
                tick(200);
                tx_vld = 1'b1;
            end
            begin : g_master
                start_c(); write_byte(8'hA1, a); read_byte(1'b1, d); stop_c();
            end
        join
`ifdef I2C_SLAVE_STRETCH_EN
        n_tests++;
        if (d !== 8'hC3 || n_udr != u0) begin n_fail++; $display("FAIL late_byte: got %h udr=%0d expected c3 udr=0", d, n_udr - u0); end
        n_tests++;
        if (scl_max < 200) begin n_fail++; $display("FAIL late_stretch: got %0d low cycles expected >=200", scl_max); end
`else
        n_tests++;
        if (d !== 8'hFF || n_udr - u0 != 1) begin n_fail++; $display("FAIL late_byte: got %h udr=%0d expected ff udr=1", d, n_udr - u0); end
        n_tests++;
        if (scl_max != 0) begin n_fail++; $display("FAIL late_scl: got %0d low cycles expected 0", scl_max); end
`endif
    endtask

    task automatic test_back_to_back();
        logic a0, a1; logic [7:0] d0, d1; int rx0, tr0;
        rx0 = n_rx; tr0 = n_txreq;
        tx_dat = 8'hC3; tx_vld = 1'b1;
        start_c(); write_byte(8'hA0, a0); write_byte(8'h11, a1);
        n_tests++;
        if ({a0, a1} !== 2'b00 || rw !== 1'b0) begin n_fail++; $display("FAIL b2b_write: got acks=%b rw=%b expected 00 rw=0", {a0, a1}, rw); end
        start_c(); write_byte(8'hA1, a0);
        n_tests++;
        if (a0 !== 1'b0 || rw !== 1'b1 || sel !== 1'b1) begin n_fail++; $display("FAIL b2b_sr: got ack=%b rw=%b sel=%b expected 0 1 1", a0, rw, sel); end
        read_byte(1'b0, d0); read_byte(1'b1, d1);
        stop_c();
        n_tests++;
        if ({d0, d1} !== 16'hC3C3) begin n_fail++; $display("FAIL b2b_read: got %h expected c3c3", {d0, d1}); end
        n_tests++;
        if (n_rx - rx0 != 1 || last_rx !== 8'h11 || n_txreq - tr0 != 2) begin
            n_fail++; $display("FAIL b2b_pulses: got rx=%0d dat=%h txreq=%0d expected 1 11 2", n_rx - rx0, last_rx, n_txreq - tr0);
        end
    endtask

    task automatic test_reset_glitch();
        logic a, rd; int low0, sto0;
        start_c();
        for (int i = 7; i >= 0; i--) bit_io(((8'hA0 >> i) & 8'h01) != 0, rd);
        n_tests++;
        if (sda_out !== 1'b0) begin n_fail++; $display("FAIL rst_pre_ack: got sda_out=%b expected 0", sda_out); end
        rst = 1'b0; #1;
        n_tests++;
        if (sda_out !== 1'b1 || scl_out !== 1'b1) begin n_fail++; $display("FAIL rst_release: got sda_out=%b scl_out=%b expected 1 1", sda_out, scl_out); end
        tick(3); rst = 1'b1; tick(5);
        sto0 = n_sto;
        stop_c();
        // single-cycle SDA glitch while SCL high
        m_sda = 1'b0; tick(1); m_sda = 1'b1; tick(10);
        low0 = n_sda_low;
        m_scl = 1'b0; tick(Q);
        write_byte(8'hA0, a);
        n_tests++;
        if (a !== 1'b1 || sel !== 1'b0 || n_sda_low != low0 || n_sto != sto0) begin
            n_fail++; $display("FAIL glitch_start: got ack=%b sel=%b lowcyc=%0d sto=%0d expected 1 0 0 0", a, sel, n_sda_low - low0, n_sto - sto0);
        end
        stop_c();
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read_nack();
        test_underrun_stretch();
        test_back_to_back();
        test_reset_glitch();
        n_tests++;
        if (n_both != 0) begin n_fail++; $display("FAIL stb_req_overlap: got %0d cycles expected 0", n_both); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
